// File: rtl/mem_pkg.sv
// Shared constants for the memory blocks (RAM read latency, FWFT output latency).
package mem_pkg;

  // Synchronous RAM read: one cycle in the address register, one in the output register.
  localparam int RAM_RD_LATENCY = 2;

  // Write accept to head-of-queue visible on an empty FWFT FIFO.
  localparam int FWFT_LATENCY = 3;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with enable and registered output.
module mem_sdp_ram #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 1024,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; the array is never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port; output register holds its value while re is low.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_fifo_fwft.sv
// First-word-fall-through FIFO on a 2-cycle RAM: prefetch pipeline
// (address reg, RAM output reg, head reg) plus one skid entry hides the read latency.
module mem_fifo_fwft
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 1024,
  parameter int AF_THRESH  = DEPTH - 8,
  parameter int AE_THRESH  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_wr,
  output logic                    o_full,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_rvalid,
  input  logic                    i_rd,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_almost_full,
  output logic                    o_almost_empty,
  output logic                    o_overflow,
  output logic                    o_underflow,
  input  logic                    i_clr_err
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = cnt_width(DEPTH);
  localparam int S_ADDR = 1;
  localparam int S_DOUT = RAM_RD_LATENCY;

  // Extra MSB on the pointers separates "RAM holds DEPTH unread" from "none unread".
  logic [AW:0]             wr_ptr, rd_ptr;
  logic [AW-1:0]           rd_addr;
  logic [DATA_WIDTH-1:0]   ram_q, skid_data;
  logic [S_DOUT:S_ADDR]    vld_pipe;
  logic                    skid_vld;
  logic                    wr_ok, pop, ram_avail, s2_go, rd_en, issue;
  logic [CW-1:0]           count_nxt;

  // Handshakes. The pipeline is elastic: a stage advances when the next one
  // is empty or advancing, so a stalled head backs up into skid, RAM output, address.
  always_comb begin
    wr_ok     = i_wr && !o_full && !i_rst;
    pop       = i_rd && o_rvalid;
    ram_avail = (wr_ptr != rd_ptr);
    s2_go     = vld_pipe[S_DOUT] && (!skid_vld || pop);
    rd_en     = vld_pipe[S_ADDR] && (!vld_pipe[S_DOUT] || s2_go) && !i_rst;
    issue     = ram_avail && (!vld_pipe[S_ADDR] || rd_en);
    unique case ({wr_ok, pop})
      2'b10:   count_nxt = o_count + 1'b1;
      2'b01:   count_nxt = o_count - 1'b1;
      default: count_nxt = o_count;
    endcase
  end

  // Storage. Write address is never the address being read: the only RAM slot
  // still needed by the pipeline is the one in the address stage, and reaching it
  // would require a write while full.
  mem_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (i_clk),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (i_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // Pointers and prefetch stage valids.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      vld_pipe <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      vld_pipe[S_ADDR] <= issue || (vld_pipe[S_ADDR] && !rd_en);
      vld_pipe[S_DOUT] <= rd_en || (vld_pipe[S_DOUT] && !s2_go);
    end
  end

  // Read address register for the RAM (datapath only, no reset).
  always_ff @(posedge i_clk) begin
    if (issue) rd_addr <= rd_ptr[AW-1:0];
  end

  // Occupancy and level flags, all registered from the same next-count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_count        <= '0;
      o_full         <= 1'b0;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
    end else begin
      o_count        <= count_nxt;
      o_full         <= (count_nxt == CW'(DEPTH));
      o_almost_full  <= (count_nxt >= CW'(AF_THRESH));
      o_almost_empty <= (count_nxt <= CW'(AE_THRESH));
    end
  end

  // Head register and its skid: a pop refills head from skid first, then from RAM output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
      skid_vld <= 1'b0;
    end else if (pop) begin
      if (skid_vld) begin
        o_rdata  <= skid_data;
        skid_vld <= s2_go;
      end else begin
        o_rvalid <= s2_go;
        if (s2_go) o_rdata <= ram_q;
      end
    end else if (!o_rvalid) begin
      o_rvalid <= s2_go;
      if (s2_go) o_rdata <= ram_q;
    end else if (s2_go) begin
      skid_vld <= 1'b1;
    end
  end

  // Skid data capture whenever RAM output lands behind a held or refilled head.
  always_ff @(posedge i_clk) begin
    if (s2_go && (pop ? skid_vld : o_rvalid)) skid_data <= ram_q;
  end

  // Sticky error flags; a new error on the clearing edge wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wr && o_full)        o_overflow  <= 1'b1;
      else if (i_clr_err)        o_overflow  <= 1'b0;
      if (i_rd && !o_rvalid)     o_underflow <= 1'b1;
      else if (i_clr_err)        o_underflow <= 1'b0;
    end
  end

endmodule
